muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a new operation; sampled only when the unit can accept.
REQ-006 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1_val  input  32  operand A, from the register file's rs1 read port.
REQ-008 rs2_val  input  32  operand B, from the register file's rs2 read port.
REQ-009 rd_index_in  input  5  destination register tag.
REQ-010 busy  output  1  high while an operation is in flight (CALC state).
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 result  output  32  operation result; valid when done=1.
REQ-013 rd_index_out  output  5  latched destination tag, drives register file rd_index.
REQ-014 rd_w  output  1  register file write enable; equals done.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-016 SHALL accept start in IDLE or DONE (back-to-back); start in CALC is ignored with no state change.
REQ-017 On accept, SHALL latch funct3, rs1_val, rs2_val, rd_index_in; later input changes have no effect.
REQ-018 MUL family: radix-2 shift-add over a 64-bit product, one bit per cycle, 32 CALC cycles.
REQ-019 Signed ops: operate on magnitudes, negate the result at the end; MULH treats both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned.
REQ-020 MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
REQ-021 DIV family: restoring division, one quotient bit per cycle, 32 CALC cycles.
REQ-022 Signed DIV: quotient sign is sign(a) XOR sign(b). Signed REM: remainder sign follows the dividend. Quotient truncates toward zero.
REQ-023 Divide by zero SHALL bypass CALC and enter DONE the cycle after accept: DIV/DIVU result 0xFFFFFFFF; REM/REMU result rs1_val.
REQ-024 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL bypass CALC: DIV result 0x80000000; REM result 0.
REQ-025 Latency: done=1 in exactly the 33rd cycle after the accept cycle for normal ops, and in the 1st cycle after accept for bypass cases.
REQ-026 done SHALL be high for exactly one cycle per accepted op; result and rd_index_out hold stable through that whole cycle, because the register file writes on the falling edge.
REQ-027 result and rd_index_out SHALL retain their last values after done drops.
REQ-028 busy=1 exactly in CALC; busy=0 in IDLE and DONE.
REQ-029 DONE with no start SHALL return to IDLE; DONE with start SHALL accept the new op (CALC, or DONE again for a bypass case).
REQ-030 rd_index_in=0 SHALL still execute and pulse done; the register file discards the write.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, rd_w=0, result=0, rd_index_out=0, and clear internal accumulators.
REQ-032 Reset during CALC or DONE SHALL abort the op with no done pulse; start in the same cycle as rst is ignored.

Verification
REQ-033 MUL 7 x -3, rd=5 -> done 33 cycles after start, result 0xFFFFFFEB, rd_index_out 5, rd_w=1 for one cycle.
REQ-034 MULH/MULHSU/MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> results 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively.
REQ-035 DIV -7/2 and REM -7/2 -> results 0xFFFFFFFD and 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-036 DIVU 5/0 and REM 5/0 -> done 1 cycle after start, results 0xFFFFFFFF and 5; DIV 0x80000000/-1 -> 0x80000000.
REQ-037 Start pulsed during CALC with new operands -> ignored, first result unaffected; start held in the DONE cycle -> second op accepted with no IDLE gap.
REQ-038 rst asserted at CALC cycle 10 -> next cycle busy=0, done=0, result=0, and no done pulse follows.

Source files
------------

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with single-cycle bypass for divide-by-zero and overflow.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_index_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_index_out,
  output logic        rd_w
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [63:0] r_acc;
  logic [31:0] r_b;
  logic        r_neg;
  logic [4:0]  r_rd;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;
  logic [4:0]  r_rd_out;

  logic        w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic        w_div_zero, w_overflow, w_bypass;
  logic [31:0] w_bypass_res;

  always_comb begin
    w_is_div     = funct3[2];
    w_a_signed   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
    w_b_signed   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    w_a_neg      = w_a_signed & rs1_val[31];
    w_b_neg      = w_b_signed & rs2_val[31];
    w_a_mag      = w_a_neg ? -rs1_val : rs1_val;
    w_b_mag      = w_b_neg ? -rs2_val : rs2_val;
    w_div_zero   = (rs2_val == '0);
    w_overflow   = !funct3[0] && (rs1_val == 32'h8000_0000) && (rs2_val == '1);
    w_bypass     = w_is_div && (w_div_zero || w_overflow);
    w_bypass_res = '0;
    if (w_div_zero)
      w_bypass_res = funct3[1] ? rs1_val : '1;
    else
      w_bypass_res = funct3[1] ? '0 : 32'h8000_0000;
  end

  // r_acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [32:0] w_sum, w_rem_sh;
  logic [31:0] w_sub;
  logic [63:0] w_next, w_prod;
  logic [31:0] w_quo, w_rem, w_final;

  always_comb begin
    w_sum    = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_b : 32'd0)};
    w_rem_sh = {r_acc[63:32], r_acc[31]};
    w_sub    = w_rem_sh[31:0] - r_b;
    if (r_funct3[2]) begin
      if (w_rem_sh >= {1'b0, r_b})
        w_next = {w_sub, r_acc[30:0], 1'b1};
      else
        w_next = {w_rem_sh[31:0], r_acc[30:0], 1'b0};
    end else begin
      w_next = {w_sum, r_acc[31:1]};
    end
    w_prod = r_neg ? -w_next : w_next;
    w_quo  = r_neg ? -w_next[31:0] : w_next[31:0];
    w_rem  = r_neg ? -w_next[63:32] : w_next[63:32];
    if (r_funct3[2])
      w_final = r_funct3[1] ? w_rem : w_quo;
    else
      w_final = (r_funct3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_funct3 <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        CALC: begin
          r_acc <= w_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_final;
            r_rd_out <= r_rd;
          end
        end
        default: begin
          if (start) begin
            r_funct3 <= funct3;
            r_rd     <= rd_index_in;
            if (w_bypass) begin
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_result <= w_bypass_res;
              r_rd_out <= rd_index_in;
            end else begin
              r_state <= CALC;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_b     <= w_is_div ? w_b_mag : w_a_mag;
              r_acc   <= {32'd0, (w_is_div ? w_a_mag : w_b_mag)};
              r_neg   <= (funct3 == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign rd_w         = r_done;
  assign result       = r_result;
  assign rd_index_out = r_rd_out;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, randomized ops against
// an arithmetic reference model, start handling, back-to-back and reset abort.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_index_in;
  logic        busy, done, rd_w;
  logic [31:0] result;
  logic [4:0]  rd_index_out;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_index_in(rd_index_in),
    .busy(busy), .done(done), .result(result),
    .rd_index_out(rd_index_out), .rd_w(rd_w)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'b001: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'b010: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Drives one op, scrambles inputs after accept, waits (bounded) for done; lat=-1 on timeout.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] res,
                        output logic [4:0] rdo, output logic rdw, output logic done_after,
                        output logic [31:0] res_after);
    start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; rd_index_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
    funct3 = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom; rd_index_in = 5'($urandom);
    lat = -1; res = '0; rdo = '0; rdw = 1'b0; done_after = 1'b0; res_after = '0;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin lat = n; break; end
      @(posedge clk); #1;
    end
    if (lat != -1) begin
      res = result; rdo = rd_index_out; rdw = rd_w;
      @(posedge clk); #1;
      done_after = done; res_after = result;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd4; rd_index_in = 5'd1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b need 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b need 0", done); end
    n_checks++; if (rd_w !== 1'b0) begin n_fail++; $display("FAIL reset_rd_w got %b need 0", rd_w); end
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h need 0", result); end
    n_checks++; if (rd_index_out !== 5'd0) begin n_fail++; $display("FAIL reset_rd_out got %0d need 0", rd_index_out); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [2:0]  f_t  [13] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b101,
                               3'b111, 3'b101, 3'b110, 3'b100, 3'b110, 3'b000};
    logic [31:0] a_t  [13] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                               32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000,
                               32'h80000000, 32'd6};
    logic [31:0] b_t  [13] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                               32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7};
    logic [31:0] e_t  [13] = '{32'hFFFFFFEB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000,
                               32'd0, 32'd42};
    int          l_t  [13] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33};
    logic [4:0]  rd_t [13] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                               5'd11, 5'd12, 5'd0};
    int lat; logic [31:0] res, res_after; logic [4:0] rdo; logic rdw, dafter;
    for (int i = 0; i < 13; i++) begin
      run_op(f_t[i], a_t[i], b_t[i], rd_t[i], lat, res, rdo, rdw, dafter, res_after);
      n_checks++; if (lat != l_t[i]) begin n_fail++; $display("FAIL dir%0d_latency got %0d need %0d", i, lat, l_t[i]); end
      n_checks++; if (res !== e_t[i]) begin n_fail++; $display("FAIL dir%0d_result got %h need %h", i, res, e_t[i]); end
      n_checks++; if (rdo !== rd_t[i]) begin n_fail++; $display("FAIL dir%0d_rd_out got %0d need %0d", i, rdo, rd_t[i]); end
      n_checks++; if (rdw !== 1'b1) begin n_fail++; $display("FAIL dir%0d_rd_w got %b need 1", i, rdw); end
      n_checks++; if (dafter !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width got %b need 0", i, dafter); end
      n_checks++; if (res_after !== e_t[i]) begin n_fail++; $display("FAIL dir%0d_result_hold got %h need %h", i, res_after, e_t[i]); end
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] res, res_after, a, b, exp; logic [4:0] rdo, rd; logic rdw, dafter; logic [2:0] f;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom);
      rd = 5'($urandom);
      case ($urandom_range(0, 7))
        0: a = 32'd0; 1: a = 32'hFFFFFFFF; 2: a = 32'h80000000; default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0; 1: b = 32'hFFFFFFFF; 2: b = 32'h80000000; default: b = $urandom;
      endcase
      exp = ref_model(f, a, b);
      run_op(f, a, b, rd, lat, res, rdo, rdw, dafter, res_after);
      n_checks++; if (lat != exp_lat(f, a, b)) begin n_fail++; $display("FAIL rnd%0d_latency f=%0d got %0d need %0d", i, f, lat, exp_lat(f, a, b)); end
      n_checks++; if (res !== exp) begin n_fail++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h got %h need %h", i, f, a, b, res, exp); end
      n_checks++; if (rdo !== rd) begin n_fail++; $display("FAIL rnd%0d_rd_out got %0d need %0d", i, rdo, rd); end
      n_checks++; if (dafter !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_done_width got %b need 0", i, dafter); end
    end
  endtask

  task automatic test_ignore_start_in_calc;
    int lat;
    start = 1'b1; funct3 = 3'b000; rs1_val = 32'd1234; rs2_val = 32'd5678; rd_index_in = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy_calc got %b need 1", busy); end
    start = 1'b1; funct3 = 3'b101; rs1_val = 32'd1; rs2_val = 32'd0; rd_index_in = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL ign_no_restart got busy=%b done=%b need busy=1 done=0", busy, done); end
    lat = -1;
    for (int n = 7; n <= 45; n++) begin
      if (done) begin lat = n; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL ign_latency got %0d need 33", lat); end
    n_checks++; if (result !== ref_model(3'b000, 32'd1234, 32'd5678)) begin n_fail++; $display("FAIL ign_result got %h need %h", result, ref_model(3'b000, 32'd1234, 32'd5678)); end
    n_checks++; if (rd_index_out !== 5'd9) begin n_fail++; $display("FAIL ign_rd_out got %0d need 9", rd_index_out); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle_after got busy=%b done=%b need 0 0", busy, done); end
  endtask

  task automatic test_back_to_back;
    int lat;
    start = 1'b1; funct3 = 3'b101; rs1_val = 32'd100; rs2_val = 32'd7; rd_index_in = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin lat = n; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (lat != 33 || result !== 32'd14) begin n_fail++; $display("FAIL b2b_first got lat=%0d res=%h need lat=33 res=0000000e", lat, result); end
    start = 1'b1; funct3 = 3'b111; rs1_val = 32'd100; rs2_val = 32'd7; rd_index_in = 5'd6;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_no_gap got busy=%b done=%b need busy=1 done=0", busy, done); end
    n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL b2b_hold_during_calc got %h need 0000000e", result); end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin lat = n; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b_second_latency got %0d need 33", lat); end
    n_checks++; if (result !== 32'd2 || rd_index_out !== 5'd6) begin n_fail++; $display("FAIL b2b_second got res=%h rd=%0d need res=00000002 rd=6", result, rd_index_out); end
    start = 1'b1; funct3 = 3'b101; rs1_val = 32'd9; rs2_val = 32'd0; rd_index_in = 5'd7;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (done !== 1'b1 || result !== 32'hFFFFFFFF || rd_index_out !== 5'd7) begin n_fail++; $display("FAIL b2b_bypass got done=%b res=%h rd=%0d need done=1 res=ffffffff rd=7", done, result, rd_index_out); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_bypass_width got %b need 0", done); end
  endtask

  task automatic test_reset_mid_calc;
    logic seen_done, seen_busy;
    start = 1'b1; funct3 = 3'b011; rs1_val = 32'hFFFFFFFF; rs2_val = 32'hFFFFFFFF; rd_index_in = 5'd12;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1; funct3 = 3'b000; rs1_val = 32'd2; rs2_val = 32'd3; rd_index_in = 5'd13;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstcalc_busy got %b need 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstcalc_done got %b need 0", done); end
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL rstcalc_result got %h need 0", result); end
    n_checks++; if (rd_index_out !== 5'd0) begin n_fail++; $display("FAIL rstcalc_rd_out got %0d need 0", rd_index_out); end
    seen_done = 1'b0; seen_busy = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rstcalc_no_done got %b need 0", seen_done); end
    n_checks++; if (seen_busy !== 1'b0) begin n_fail++; $display("FAIL rstcalc_start_ignored got busy_seen=%b need 0", seen_busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_index_in = '0;
    test_reset;
    test_directed;
    test_random;
    test_ignore_start_in_calc;
    test_back_to_back;
    test_reset_mid_calc;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
